// File: rtl/add16_pkg.sv
// rtl/add16_pkg.sv - shared adder width, word type and round-robin pointer helper
package add16_pkg;

  localparam int ADD_W = 16;

  typedef logic [ADD_W-1:0] add_word_t;

  // Pointer moves just past the winner; an out-of-range grant leaves it where it was.
  function automatic int rr_next(input int ptr, input int g, input int n);
    if (g < 0 || g >= n) return ptr;
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/add16_core.sv
// rtl/add16_core.sv - combinational 16-bit ripple adder built from full-adder cells
module add16_core
  import add16_pkg::*;
(
  input  add_word_t a,
  input  add_word_t b,
  input  logic      cin,
  output add_word_t sum,
  output logic      cout
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < ADD_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/add16_arbiter.sv
// rtl/add16_arbiter.sv - round-robin arbiter sharing one add16_core among NUM_REQ requesters
// ADD16_ARB_CARRY_EN adds the rsp_carry output and its register.
module add16_arbiter
  import add16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output add_word_t              rsp_sum,
`ifdef ADD16_ARB_CARRY_EN
  output logic                   rsp_carry,
`endif
  output logic [ID_W-1:0]        rsp_id
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_found;
  logic            can_accept;
  logic            accept;
  add_word_t       a_sel;
  add_word_t       b_sel;
  add_word_t       sum;
  logic            cout;

  // Scan from ptr upward, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign accept     = can_accept && gnt_found;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        req_ready[i] = accept;
        a_sel        = req_a[ADD_W*i +: ADD_W];
        b_sel        = req_b[ADD_W*i +: ADD_W];
      end
    end
  end

  add16_core u_core (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (1'b0),
    .sum  (sum),
`ifdef ADD16_ARB_CARRY_EN
    .cout (cout)
`else
    .cout ()
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= sum;
      rsp_id    <= gnt_id;
      ptr       <= ID_W'(rr_next(int'(ptr), int'(gnt_id), NUM_REQ));
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ADD16_ARB_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_carry <= 1'b0;
    end else if (accept) begin
      rsp_carry <= cout;
    end
  end
`endif

endmodule

// File: tb/tb_add16_arbiter.sv
// tb/tb_add16_arbiter.sv - self-checking bench for add16_arbiter against a behavioural model
module tb_add16_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_sum;
  logic [IW-1:0]   rsp_id;
`ifdef ADD16_ARB_CARRY_EN
  logic            rsp_carry;
`endif

  always #5 clk = ~clk;

  add16_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
`ifdef ADD16_ARB_CARRY_EN
    .rsp_carry (rsp_carry),
`endif
    .rsp_id    (rsp_id)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_sum;
  int          m_id;
  logic        m_carry;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] r;
    g = model_grant();
    r = '0;
    if ((!m_valid || rsp_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]     = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic tick(output int acc);
    int g;
    logic can;
    logic [16:0] s;
    g   = model_grant();
    can = !m_valid || rsp_ready;
    acc = (can && g >= 0) ? g : -1;
    @(posedge clk);
    if (acc >= 0) begin
      s       = {1'b0, req_a[16*acc +: 16]} + {1'b0, req_b[16*acc +: 16]};
      m_valid = 1'b1;
      m_sum   = s[15:0];
      m_carry = s[16];
      m_id    = acc;
      m_ptr   = (acc + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_id = 0; m_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_id = 0; m_carry = 1'b0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0000", rsp_sum); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int acc;
    set_req(2, 16'h1234, 16'h0101);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    tick(acc);
    req_valid[2] = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== 16'h1335) begin errors++; $display("FAIL single_sum: got %h expected 1335", rsp_sum); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
  endtask

  task automatic test_overflow();
    int acc;
    set_req(0, 16'hFFFF, 16'h0001);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ovf_ready: got %b expected 0001", req_ready); end
    tick(acc);
    req_valid[0] = 1'b0;
    #1;
    checks++; if (rsp_sum !== 16'h0000) begin errors++; $display("FAIL ovf_sum: got %h expected 0000", rsp_sum); end
`ifdef ADD16_ARB_CARRY_EN
    checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL ovf_carry: got %b expected 1", rsp_carry); end
`endif
    tick(acc);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_async_reset();
    int acc;
    set_req(1, 16'h00AA, 16'h0055);
    rsp_ready = 1'b0;
    tick(acc);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 16'h0) begin errors++; $display("FAIL async_sum: got %h expected 0000", rsp_sum); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL async_id: got %0d expected 0", rsp_id); end
    m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_id = 0; m_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL no_replay: got %b expected 0", rsp_valid); end
    rsp_ready = 1'b1;
  endtask

  task automatic test_round_robin();
    int acc;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    rsp_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << (k % N))) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << (k % N)); end
      tick(acc);
      if (acc >= 0) set_req(acc, 16'($urandom), 16'($urandom));
      #1;
      checks++; if (rsp_id !== IW'(k % N)) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, rsp_id, k % N); end
      checks++; if (rsp_sum !== m_sum) begin errors++; $display("FAIL rr_sum[%0d]: got %h expected %h", k, rsp_sum, m_sum); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [15:0] hold_sum;
    int hold_id;
    hold_sum  = m_sum;
    hold_id   = m_id;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, req_ready); end
      tick(acc);
      checks++; if (rsp_sum !== hold_sum || rsp_id !== IW'(hold_id) || rsp_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b expected %h/%0d/1", k, rsp_sum, rsp_id, rsp_valid, hold_sum, hold_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== (4'b0001 << ((hold_id + 1) % N))) begin errors++; $display("FAIL bp_resume: got %b expected %b", req_ready, 4'b0001 << ((hold_id + 1) % N)); end
    tick(acc);
    req_valid = '0;
    tick(acc);
  endtask

  task automatic test_ptr_skip();
    int acc;
    do_reset();
    rsp_ready = 1'b1;
    set_req(1, 16'($urandom), 16'($urandom));
    tick(acc);
    req_valid = '0;
    tick(acc);
    set_req(1, 16'h0100, 16'h0002);
    set_req(3, 16'h3000, 16'h0004);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_first: got %b expected 1000", req_ready); end
    tick(acc);
    req_valid[3] = 1'b0;
    #1;
    checks++; if (rsp_id !== 2'd3 || rsp_sum !== 16'h3004) begin errors++; $display("FAIL skip_rsp3: got %0d/%h expected 3/3004", rsp_id, rsp_sum); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL skip_second: got %b expected 0010", req_ready); end
    tick(acc);
    req_valid[1] = 1'b0;
    #1;
    checks++; if (rsp_id !== 2'd1 || rsp_sum !== 16'h0102) begin errors++; $display("FAIL skip_rsp1: got %0d/%h expected 1/0102", rsp_id, rsp_sum); end
    set_req(1, 16'h0001, 16'h0001);
    set_req(3, 16'h0003, 16'h0003);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_ptr2: got %b expected 1000", req_ready); end
    tick(acc);
    req_valid = '0;
    tick(acc);
  endtask

  task automatic test_random();
    int acc;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 16'($urandom), 16'($urandom));
      #1;
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, exp_ready()); end
      checks++; if (rsp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, rsp_valid, m_valid); end
      if (m_valid) begin
        checks++; if (rsp_sum !== m_sum || rsp_id !== IW'(m_id)) begin
          errors++; $display("FAIL rnd_rsp[%0d]: got %h/%0d expected %h/%0d", c, rsp_sum, rsp_id, m_sum, m_id);
        end
`ifdef ADD16_ARB_CARRY_EN
        checks++; if (rsp_carry !== m_carry) begin errors++; $display("FAIL rnd_carry[%0d]: got %b expected %b", c, rsp_carry, m_carry); end
`endif
      end
      tick(acc);
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_async_reset();
    test_round_robin();
    test_backpressure();
    test_ptr_skip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add16_arbiter.md
# add16_arbiter

Round-robin arbiter and sequencer that shares one 16-bit ripple adder between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and registers the sum together with the requester ID. It drives a single valid/ready response port. It sits between the client blocks and the shared adder, so that adder instances are not duplicated per client.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width (derived; do not override).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input `NUM_REQ`: bit i = requester i has an operand pair.
- `req_ready` output `NUM_REQ`: bit i = requester i's pair is accepted this cycle.
- `req_a` input `NUM_REQ*16`: operand A; slice `[16*i+15:16*i]` belongs to requester i.
- `req_b` input `NUM_REQ*16`: operand B, same slicing.
- `rsp_valid` output 1: response register holds a result.
- `rsp_ready` input 1: downstream accepts the response.
- `rsp_sum` output 16: `(a + b) mod 2^16`.
- `rsp_id` output `ID_W`: index of the requester that produced `rsp_sum`.
- `rsp_carry` output 1: carry out of bit 15. Present only with `ADD16_ARB_CARRY_EN`.

## Operation
- Round-robin pointer `ptr` (`ID_W` bits) marks the highest-priority requester.
- Grant goes to the first i with `req_valid[i]=1`, searching `ptr, ptr+1, …` modulo `NUM_REQ`.
- `can_accept = !rsp_valid || rsp_ready`.
- `req_ready[i] = can_accept && grant[i]`.
  - At most one bit of `req_ready` is high.
  - `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`.
- Acceptance happens when `req_valid[g] && req_ready[g]`. On acceptance:
  - the response register loads `sum`, `id=g` and `carry`;
  - `rsp_valid` is set to 1;
  - `ptr` becomes `(g+1) mod NUM_REQ`.
- The pointer wraps from `NUM_REQ-1` to 0. `ptr` is unchanged in any cycle with no acceptance.
- `rsp_valid=1 && rsp_ready=1` with no acceptance: `rsp_valid` clears to 0.
- `rsp_valid=1 && rsp_ready=1` with an acceptance in the same cycle: the register reloads and `rsp_valid` stays 1. Full throughput is one result per cycle.
- `rsp_valid=1 && rsp_ready=0`:
  - `rsp_sum`, `rsp_id` and `rsp_carry` hold stable;
  - `req_ready` is all zeros;
  - `ptr` is frozen.
- Arithmetic is unsigned 16-bit with carry-in 0. Overflow wraps; e.g. `0xFFFF + 0x0001` gives sum `0x0000`, carry 1.
- Requesters must hold `req_valid`, `req_a` and `req_b` until accepted. The arbiter never drops a pending request.
- Starvation bound: a continuously valid requester is granted within `NUM_REQ` accepting cycles.

## Timing
- Latency is one cycle: accepted in cycle N, result visible with `rsp_valid=1` in cycle N+1.
- Reset (`rst_n=0`, asynchronous) sets:
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`, `rsp_carry=0`, `ptr=0`;
  - hence `req_ready=0`, because no requester is valid at reset.
- Reset mid-transaction discards the held response; no result is replayed after reset.
- Reset deassertion is synchronised externally. The first grant can occur in the first cycle after release.

## Configuration
- `ADD16_ARB_CARRY_EN` defined:
  - the `rsp_carry` port and its register exist;
  - `rsp_carry` is captured at acceptance and held with `rsp_sum`.
- `ADD16_ARB_CARRY_EN` undefined:
  - the port and register are absent;
  - the adder carry-out is left unconnected;
  - all other behaviour is identical.

## Structure
- Shared package `add16_pkg`:
  - `ADD_W = 16`;
  - typedef `add_word_t` (`logic [15:0]`);
  - function `rr_next(ptr, g, n)` for the pointer update.
- One sub-module: `add16_core`, a combinational 16-bit adder (a, b, cin=0 → sum, cout) built from full-adder cells. The arbiter instantiates exactly one.
- Grant logic, pointer and response register live in `add16_arbiter`.

## Test plan
- Reset → `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`, `req_ready=0`. Assert `rst_n=0` while `rsp_valid=1` → outputs clear immediately, without waiting for a clock edge.
- Single requester 2 issues `a=0x1234`, `b=0x0101`, with `rsp_ready=1` → `req_ready[2]=1` in that cycle; next cycle `rsp_sum=0x1335`, `rsp_id=2`.
- Overflow: `a=0xFFFF`, `b=0x0001` → `rsp_sum=0x0000`; with the macro defined, `rsp_carry=1`.
- All 4 requesters valid continuously, `rsp_ready=1` → responses arrive with `rsp_id` sequence 0,1,2,3,0,… one per cycle, and `ptr` wraps 3→0.
- Backpressure: response pending, `rsp_ready=0` for 3 cycles → `rsp_sum` and `rsp_id` stable, `req_ready=0`. Then `rsp_ready=1` → next grant goes to the requester after the previous winner.
- Requesters 1 and 3 valid with `ptr=2` → requester 3 granted first, then requester 1, with `ptr` moving 2→0→2.
